// File: rtl/fir_mac_seq.sv
// Sequencer + single shared MAC for a time-multiplexed FIR: accept a sample, walk all taps, emit scaled sum.
// Optional output saturation: define FIR_MAC_SEQ_SAT_EN (default build wraps to OUT_WIDTH).
module fir_mac_seq #(
   parameter int DATA_WIDTH = 13,
   parameter int COEF_WIDTH = 13,
   parameter int TAPS       = 8,
   parameter int OUT_WIDTH  = 16,
   parameter int OUT_SHIFT  = 12
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          VIN,
   output logic                          RDY_IN,
   output logic                          SHIFT_EN,
   output logic [$clog2(TAPS)-1:0]       TAP_SEL,
   input  logic signed [DATA_WIDTH-1:0]  TAP_DATA,
   input  logic signed [COEF_WIDTH-1:0]  COEF,
   output logic signed [OUT_WIDTH-1:0]   DOUT,
   output logic                          VOUT,
   input  logic                          ROUT_RDY,
   output logic                          BUSY
);

   localparam int SEL_W  = $clog2(TAPS);
   localparam int PROD_W = DATA_WIDTH + COEF_WIDTH;
   localparam int ACC_W  = PROD_W + SEL_W;
   localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(TAPS - 1);

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t                   state;
   logic signed [ACC_W-1:0]  acc;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0]  prod_ext;
   logic signed [ACC_W-1:0]  sum;
   logic signed [ACC_W-1:0]  scaled;
   logic signed [OUT_WIDTH-1:0] dout_nx;

   // Full-precision product; ACC_W leaves room for TAPS worst-case products.
   assign prod     = PROD_W'(TAP_DATA) * PROD_W'(COEF);
   assign prod_ext = ACC_W'(prod);
   // Tap 0 restarts the sum, so the accumulator never needs an explicit clear.
   assign sum      = (TAP_SEL == '0) ? prod_ext : acc + prod_ext;
   assign scaled   = sum >>> OUT_SHIFT;

`ifdef FIR_MAC_SEQ_SAT_EN
   localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
   localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

   always_comb begin
      dout_nx = OUT_WIDTH'(scaled);
      if (scaled > SAT_MAX)
         dout_nx = OUT_WIDTH'(SAT_MAX);
      else if (scaled < SAT_MIN)
         dout_nx = OUT_WIDTH'(SAT_MIN);
   end
`else
   assign dout_nx = OUT_WIDTH'(scaled);
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         acc     <= '0;
         DOUT    <= '0;
         TAP_SEL <= '0;
         VOUT    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               TAP_SEL <= '0;
               if (VIN)
                  state <= S_MAC;
            end
            S_MAC: begin
               acc <= sum;
               if (TAP_SEL == LAST_TAP) begin
                  DOUT    <= dout_nx;
                  VOUT    <= 1'b1;
                  TAP_SEL <= '0;
                  state   <= S_OUT;
               end else begin
                  TAP_SEL <= TAP_SEL + SEL_W'(1);
               end
            end
            S_OUT: begin
               if (ROUT_RDY) begin
                  VOUT  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign RDY_IN   = (state == S_IDLE);
   assign SHIFT_EN = VIN & RDY_IN;
   assign BUSY     = (state != S_IDLE);

endmodule

// File: tb/tb_fir_mac_seq.sv
// Scoreboard bench for fir_mac_seq: models the delay line and coefficient source, predicts each result at accept time.
module tb_fir_mac_seq;
   localparam int DATA_WIDTH = 13;
   localparam int COEF_WIDTH = 13;
   localparam int TAPS       = 8;
   localparam int OUT_WIDTH  = 16;
   localparam int OUT_SHIFT  = 12;
   localparam int SEL_W      = $clog2(TAPS);

   logic                         CLK = 1'b0;
   logic                         RST = 1'b1;
   logic                         VIN = 1'b0;
   logic                         ROUT_RDY = 1'b1;
   logic                         RDY_IN, SHIFT_EN, VOUT, BUSY;
   logic [SEL_W-1:0]             TAP_SEL;
   logic signed [DATA_WIDTH-1:0] TAP_DATA;
   logic signed [COEF_WIDTH-1:0] COEF;
   logic signed [OUT_WIDTH-1:0]  DOUT;

   logic                         mode_const = 1'b1;
   logic signed [DATA_WIDTH-1:0] c_data = '0;
   logic signed [COEF_WIDTH-1:0] c_coef = '0;
   logic signed [DATA_WIDTH-1:0] din = '0;
   logic signed [DATA_WIDTH-1:0] dl [TAPS] = '{default: '0};

   int     total = 0;
   int     bad   = 0;
   int     pops  = 0;
   int     cyc   = 0;
   longint exp_q[$];
   longint model_sum;

   fir_mac_seq #(
      .DATA_WIDTH(DATA_WIDTH), .COEF_WIDTH(COEF_WIDTH), .TAPS(TAPS),
      .OUT_WIDTH(OUT_WIDTH), .OUT_SHIFT(OUT_SHIFT)
   ) dut (
      .CLK(CLK), .RST(RST), .VIN(VIN), .RDY_IN(RDY_IN), .SHIFT_EN(SHIFT_EN),
      .TAP_SEL(TAP_SEL), .TAP_DATA(TAP_DATA), .COEF(COEF), .DOUT(DOUT),
      .VOUT(VOUT), .ROUT_RDY(ROUT_RDY), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   assign TAP_DATA = mode_const ? c_data : dl[TAP_SEL];
   assign COEF     = c_coef;

   task automatic chk(input string tag, input longint got, input longint want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, want);
      end
   endtask

   function automatic longint exp_of(input longint s_in);
      longint s;
`ifndef FIR_MAC_SEQ_SAT_EN
      logic signed [OUT_WIDTH-1:0] w;
`endif
      s = s_in >>> OUT_SHIFT;
`ifdef FIR_MAC_SEQ_SAT_EN
      if (s > (64'sd1 <<< (OUT_WIDTH - 1)) - 1) return (64'sd1 <<< (OUT_WIDTH - 1)) - 1;
      if (s < -(64'sd1 <<< (OUT_WIDTH - 1)))    return -(64'sd1 <<< (OUT_WIDTH - 1));
      return s;
`else
      w = s[OUT_WIDTH-1:0];
      return longint'(w);
`endif
   endfunction

   // Delay line model plus expected-result push at every accepted sample.
   always @(posedge CLK) begin
      cyc <= cyc + 1;
      if (SHIFT_EN) begin
         model_sum = longint'(din) * longint'(c_coef);
         for (int j = 1; j < TAPS; j++)
            model_sum += longint'(dl[j-1]) * longint'(c_coef);
         for (int j = TAPS - 1; j > 0; j--)
            dl[j] <= dl[j-1];
         dl[0] <= din;
      end
      if (RST)
         exp_q.delete();
      else if (SHIFT_EN)
         exp_q.push_back(exp_of(mode_const ? longint'(c_data) * longint'(c_coef) * TAPS : model_sum));
   end

   // Compare on every output handshake; an empty queue yields an impossible expectation.
   always @(negedge CLK) begin
      longint e;
      if (!RST && VOUT && ROUT_RDY) begin
         e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'sd999999;
         chk("dout", DOUT, e);
         pops++;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_vout();
      int n = 0;
      while (!VOUT && n < 40) begin
         tick();
         n++;
      end
      chk("vout_timeout", VOUT, 1);
   endtask

   initial begin
      int     n;
      int     last;
      logic   seen;

      // reset with VIN held, then one constant-data sample
      c_data = 13'sd1000; c_coef = 13'sd2048; mode_const = 1'b1;
      RST = 1'b1; VIN = 1'b1; ROUT_RDY = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_busy", BUSY, 0);
         chk("rst_tap", TAP_SEL, 0);
         chk("rst_vout", VOUT, 0);
      end
      RST = 1'b0;
      #1;
      chk("post_rdy", RDY_IN, 1);
      chk("post_shift", SHIFT_EN, 1);
      chk("post_vout", VOUT, 0);
      chk("post_dout", DOUT, 0);
      chk("post_tap", TAP_SEL, 0);
      tick();
      VIN = 1'b0;
      for (int i = 0; i < TAPS; i++) begin
         if (i > 0) tick();
         chk("tap_step", TAP_SEL, i);
         chk("vout_early", VOUT, 0);
      end
      tick();
      chk("vout_latency", VOUT, 1);
      tick();
      chk("idle_after", BUSY, 0);

      // overflow corner
      c_data = -13'sd4096; c_coef = -13'sd4096;
      VIN = 1'b1;
      tick();
      VIN = 1'b0;
      wait_vout();
      tick();

      // backpressure with VIN pulsing
      c_data = -13'sd300; c_coef = 13'sd1500;
      ROUT_RDY = 1'b0; VIN = 1'b1;
      tick();
      VIN = 1'b0;
      wait_vout();
      for (int i = 0; i < 5; i++) begin
         VIN = (i % 2 == 0);
         #1;
         chk("bp_vout", VOUT, 1);
         chk("bp_dout", DOUT, exp_of(-64'sd300 * 1500 * TAPS));
         chk("bp_rdy", RDY_IN, 0);
         chk("bp_shift", SHIFT_EN, 0);
         tick();
      end
      VIN = 1'b0; ROUT_RDY = 1'b1;
      tick();
      chk("bp_idle", BUSY, 0);
      chk("bp_vout_clr", VOUT, 0);
      chk("bp_rdy_back", RDY_IN, 1);

      // reset in the middle of a MAC walk
      c_data = 13'sd700; c_coef = 13'sd900;
      VIN = 1'b1;
      tick();
      VIN = 1'b0;
      n = 0;
      while (TAP_SEL != 3 && n < 20) begin
         tick();
         n++;
      end
      chk("tap3_reach", TAP_SEL, 3);
      RST = 1'b1;
      tick();
      chk("mid_rst_tap", TAP_SEL, 0);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_rdy", RDY_IN, 1);
      RST = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < TAPS + 4; i++) begin
         tick();
         if (VOUT) seen = 1'b1;
      end
      chk("mid_rst_no_vout", seen, 0);

      // back-to-back impulse through the delay line model
      mode_const = 1'b0; c_coef = 13'sd2048; din = 13'sd1000;
      VIN = 1'b1; ROUT_RDY = 1'b1;
      #1;
      last = 0;
      for (int k = 0; k < 10; k++) begin
         n = 0;
         while (!SHIFT_EN && n < 30) begin
            tick();
            n++;
         end
         chk("b2b_accept", SHIFT_EN, 1);
         if (k > 0) chk("b2b_gap", cyc - last, TAPS + 2);
         last = cyc;
         tick();
         din = '0;
      end
      VIN = 1'b0;
      repeat (14) tick();
      chk("drain", exp_q.size(), 0);
      chk("pops", pops, 13);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule

// File: doc/fir_mac_seq.md
# fir_mac_seq

Sequencer and shared multiply-accumulate engine for the time-multiplexed FIR path. It accepts one input sample per handshake and pulses the tapped-delay-line shift enable. It then walks a tap index across all TAPS taps while accumulating tap × coefficient products in a single MAC, and presents the scaled result behind a valid/ready output handshake. It sits between the sample source, the tap delay line with its tap mux, the coefficient ROM, and the downstream consumer.

## Interface
- DATA_WIDTH, 13, width of input samples and of TAP_DATA.
- COEF_WIDTH, 13, width of signed coefficients (Q1.(COEF_WIDTH-1)).
- TAPS, 8, number of taps; must be ≥ 2.
- OUT_WIDTH, 16, width of DOUT.
- OUT_SHIFT, 12, arithmetic right shift applied to the accumulator before output.

Ports:
- CLK  in  1  clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- VIN  in  1  input sample valid.
- RDY_IN  out  1  block can accept a sample.
- SHIFT_EN  out  1  shift strobe to the delay line; combinational, equals VIN & RDY_IN.
- TAP_SEL  out  $clog2(TAPS)  tap index driven to the tap mux and coefficient ROM.
- TAP_DATA  in  DATA_WIDTH signed  selected tap value; combinational function of TAP_SEL.
- COEF  in  COEF_WIDTH signed  coefficient for TAP_SEL; combinational.
- DOUT  out  OUT_WIDTH signed  filter result.
- VOUT  out  1  DOUT valid.
- ROUT_RDY  in  1  downstream accepts DOUT.
- BUSY  out  1  high in MAC or OUT.

## Operation
- Accumulator width ACC_W = DATA_WIDTH+COEF_WIDTH+$clog2(TAPS), signed. Product is full precision, sign-extended to ACC_W, so no internal overflow is possible.
- FSM states: IDLE, MAC, OUT.
  - IDLE: RDY_IN=1, TAP_SEL=0. If VIN=1, SHIFT_EN=1 and the delay line captures DIN on this edge, then go to MAC.
  - MAC: one tap per cycle, TAP_SEL = 0..TAPS-1. At TAP_SEL=0, acc <= product (implicit clear). Otherwise acc <= acc + product. After the cycle with TAP_SEL=TAPS-1, register DOUT, set VOUT, go to OUT, and reset TAP_SEL to 0.
  - OUT: VOUT=1 and DOUT is held stable. When VOUT & ROUT_RDY, clear VOUT and go to IDLE.
- RDY_IN=0 in MAC and OUT. VIN there is ignored and SHIFT_EN stays 0; no sample is lost only if the source holds VIN.
- Output scaling: s = acc >>> OUT_SHIFT (floor, arithmetic). s is then narrowed to OUT_WIDTH per Configuration.
- Reset at any time:
  - state = IDLE; acc, DOUT and TAP_SEL = 0; VOUT = 0.
  - Any in-flight result is discarded.
  - The delay line contents are not touched by this block.
- Reset has priority over every other event on the same edge.

## Timing
- Reset values: RDY_IN=1, SHIFT_EN=VIN, TAP_SEL=0, DOUT=0, VOUT=0, BUSY=0.
- Accept at edge k. MAC occupies cycles k+1..k+TAPS. VOUT rises after edge k+TAPS, so latency is TAPS cycles from acceptance.
- DOUT is registered; it changes only on the edge that sets VOUT.
- If ROUT_RDY=1 in the first OUT cycle, the sequence lasts TAPS+2 cycles: IDLE 1, MAC TAPS, OUT 1. The next accept is possible TAPS+2 cycles after the previous accept.
- TAP_DATA and COEF are sampled on the same edge that TAP_SEL addresses. There is no extra pipeline stage, so both sources must be combinational.

## Configuration
- FIR_MAC_SEQ_SAT_EN defined: if s exceeds the OUT_WIDTH signed range, DOUT clamps to +2^(OUT_WIDTH-1)-1 or -2^(OUT_WIDTH-1).
- FIR_MAC_SEQ_SAT_EN undefined: DOUT = s[OUT_WIDTH-1:0], two's-complement wrap, with no saturation logic.

## Test plan
Default parameters unless noted.
- Reset: hold RST for 2 cycles with VIN=1. → During reset, state stays IDLE. After release: RDY_IN=1, VOUT=0, DOUT=0, TAP_SEL=0, and SHIFT_EN=1 only from the first post-reset cycle.
- Constant MAC: TAP_DATA=1000, COEF=2048, single VIN pulse. → TAP_SEL steps 0..7; VOUT high exactly 8 cycles after accept; DOUT=4000.
- Overflow: TAP_DATA=-4096, COEF=-4096. → s=32768. With the macro, DOUT=32767. Without the macro, DOUT=-32768.
- Backpressure: ROUT_RDY=0 for 5 cycles after VOUT, with VIN pulsing. → DOUT and VOUT are stable, RDY_IN=0, SHIFT_EN=0 throughout. The result is accepted in the cycle ROUT_RDY=1, followed by IDLE.
- Reset mid-MAC: assert RST while TAP_SEL=3. → The next cycle is IDLE with TAP_SEL=0, and VOUT never asserts for that sample.
- Back-to-back: VIN and ROUT_RDY held at 1 with a bench TAP_DATA/COEF model of an impulse (DIN=1000, COEF=2048). → SHIFT_EN pulses every 10 cycles; DOUT=500 for each of the first 8 outputs, then 0.
